// File: rtl/camera64_spi_pkg.sv
// Shared constants and types for the 64x64 dummy-camera SPI slave.
package camera64_spi_pkg;

  localparam int DIM_LOG2 = 6;
  localparam int ADDR_W   = 2 * DIM_LOG2;

  localparam logic [7:0] ID_BYTE0 = 8'hC6;
  localparam logic [7:0] ID_BYTE1 = 8'h40;

  localparam logic [7:0] CMD_READ_FRAME    = 8'h01;
  localparam logic [7:0] CMD_READ_ID       = 8'h02;
  localparam logic [7:0] CMD_WRITE_PATTERN = 8'h03;
  localparam logic [7:0] CMD_CLEAR_FRAME   = 8'h04;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_FRAME,
    ST_ID,
    ST_WPAT,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    PAT_XRAMP,
    PAT_YRAMP,
    PAT_CHECKER,
    PAT_FRAMECNT
  } pattern_t;

endpackage

// File: rtl/camera64_pattern_gen.sv
// Combinational synthetic pixel source: maps a pixel coordinate and the
// selected test pattern to an 8-bit pixel value.
module camera64_pattern_gen
  import camera64_spi_pkg::*;
(
  input  logic [DIM_LOG2-1:0] x,
  input  logic [DIM_LOG2-1:0] y,
  input  logic [1:0]          pattern,
  input  logic [7:0]          frame_cnt,
  output logic [7:0]          pixel
);

  always_comb begin
    pixel = 8'h00;
    case (pattern_t'(pattern))
      PAT_XRAMP:    pixel = {x, 2'b00};
      PAT_YRAMP:    pixel = {y, 2'b00};
      PAT_CHECKER:  pixel = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      PAT_FRAMECNT: pixel = frame_cnt;
      default:      pixel = 8'h00;
    endcase
  end

endmodule

// File: rtl/camera64_spi_slave.sv
// SPI mode-0 slave for the dummy camera: command decode FSM, bit/byte
// counters, pixel address and the MISO shift register, all in the SCLK domain.
module camera64_spi_slave
  import camera64_spi_pkg::*;
(
  input  logic       SCLK,
  input  logic       RST,
  input  logic       CSN,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [1:0] PATTERN,
  output logic [7:0] FRAME_CNT,
  output logic       BUSY
);

  state_t             state_reg, state_next;
  logic [2:0]         bit_cnt_reg;
  logic [7:0]         rx_reg;
  logic [7:0]         shift_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [1:0]         id_idx_reg;
  logic               wpat_done_reg;
  logic [1:0]         pattern_reg;
  logic [7:0]         frame_cnt_reg;

  logic               byte_end;
  logic [7:0]         rx_byte;
  logic [7:0]         pixel;
  logic [7:0]         tx_byte;
  logic               frame_load, id_load, wpat_write, clear_frame, frame_wrap;

  assign byte_end = (bit_cnt_reg == 3'd7);
  assign rx_byte  = {rx_reg[6:0], MOSI};

  camera64_pattern_gen u_pattern_gen (
    .x         (addr_reg[DIM_LOG2-1:0]),
    .y         (addr_reg[ADDR_W-1:DIM_LOG2]),
    .pattern   (pattern_reg),
    .frame_cnt (frame_cnt_reg),
    .pixel     (pixel)
  );

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_CMD && byte_end) begin
      case (rx_byte)
        CMD_READ_FRAME:    state_next = ST_FRAME;
        CMD_READ_ID:       state_next = ST_ID;
        CMD_WRITE_PATTERN: state_next = ST_WPAT;
        default:           state_next = ST_IGNORE;
      endcase
    end
  end

  // Response bytes are loaded on the edge that completes a byte, including
  // the command byte itself, so the reply starts with zero-byte latency.
  always_comb begin
    frame_load  = byte_end && (state_next == ST_FRAME);
    id_load     = byte_end && (state_next == ST_ID);
    wpat_write  = byte_end && (state_reg == ST_WPAT) && !wpat_done_reg;
    clear_frame = byte_end && (state_reg == ST_CMD) && (rx_byte == CMD_CLEAR_FRAME);
    frame_wrap  = frame_load && (addr_reg == {ADDR_W{1'b1}});
    tx_byte     = 8'h00;
    if (frame_load) begin
      tx_byte = pixel;
    end else if (id_load) begin
      case (id_idx_reg)
        2'd0:    tx_byte = ID_BYTE0;
        2'd1:    tx_byte = ID_BYTE1;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge SCLK or posedge RST or posedge CSN) begin
    if (RST || CSN) begin
      state_reg <= ST_CMD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Transaction state: cleared whenever chip select is released.
  always_ff @(posedge SCLK or posedge RST or posedge CSN) begin
    if (RST || CSN) begin
      bit_cnt_reg   <= 3'd0;
      rx_reg        <= 8'h00;
      shift_reg     <= 8'h00;
      addr_reg      <= '0;
      id_idx_reg    <= 2'd0;
      wpat_done_reg <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      rx_reg      <= rx_byte;
      if (byte_end) begin
        shift_reg <= tx_byte;
      end else begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end
      if (frame_load) begin
        addr_reg <= addr_reg + 1'b1;
      end
      if (id_load && id_idx_reg != 2'd2) begin
        id_idx_reg <= id_idx_reg + 2'd1;
      end
      if (wpat_write) begin
        wpat_done_reg <= 1'b1;
      end
    end
  end

  // Settings that survive chip-select release; only RST clears them.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      pattern_reg   <= 2'd0;
      frame_cnt_reg <= 8'h00;
    end else if (!CSN) begin
      if (wpat_write) begin
        pattern_reg <= rx_byte[1:0];
      end
      if (clear_frame) begin
        frame_cnt_reg <= 8'h00;
      end else if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  assign MISO      = shift_reg[7];
  assign MISO_OE   = (state_reg == ST_FRAME) || (state_reg == ST_ID);
  assign BUSY      = (state_reg != ST_CMD);
  assign PATTERN   = pattern_reg;
  assign FRAME_CNT = frame_cnt_reg;

endmodule
